// File: rtl/io_port_bank.sv
// io_port_bank
//   Bank of NUM_PORTS memory-mapped I/O ports, PORT_WIDTH bits each, on the
//   shared 8-bit data bus. Each port exposes four registers at
//   BASE_ADDR + 4*p + r:
//     r=0 DATA_IN  (RO)   synchronised pin value
//     r=1 DATA_OUT (RW)   drives out_port
//     r=2 PEND     (W1C)  latched rising edges, set wins over clear
//     r=3 MASK     (RW)   enables edge capture and irq contribution
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   in_addr[9:0]      data-memory address {bank selector, BUS}
//   in_write_en       bus write strobe
//   in_read_en        bus read strobe
//   in_data[7:0]      write data
//   out_data[7:0]     read data, high-Z when not selected or when writing
//   in_port           asynchronous pins, port p at [p*PORT_WIDTH +: PORT_WIDTH]
//   out_port          registered output pins, same packing
//   out_irq           OR over all ports of (PEND & MASK)
module io_port_bank #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned PORT_WIDTH = 4,
  parameter logic [9:0]  BASE_ADDR  = 10'h3F0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [9:0]                      in_addr,
  input  logic                            in_write_en,
  input  logic                            in_read_en,
  input  logic [7:0]                      in_data,
  output logic [7:0]                      out_data,
  input  logic [NUM_PORTS*PORT_WIDTH-1:0] in_port,
  output logic [NUM_PORTS*PORT_WIDTH-1:0] out_port,
  output logic                            out_irq
);

  localparam int unsigned NBITS   = NUM_PORTS * PORT_WIDTH;
  // One extra bit so the window end can reach 1024 without wrapping.
  localparam logic [10:0] ADDR_LO = {1'b0, BASE_ADDR};
  localparam logic [10:0] ADDR_HI = ADDR_LO + 11'(4 * NUM_PORTS);

  logic [NBITS-1:0] sync1_q, sync1_d;
  logic [NBITS-1:0] sync2_q, sync2_d;
  logic [NBITS-1:0] prev_q, prev_d;
  logic [NBITS-1:0] data_out_q, data_out_d;
  logic [NBITS-1:0] pend_q, pend_d;
  logic [NBITS-1:0] mask_q, mask_d;

  logic             hit_s;
  logic             wr_s;
  logic [9:0]       offset_s;
  logic [7:0]       port_idx_s;
  logic [1:0]       reg_sel_s;
  logic [NBITS-1:0] rising_s;
  logic [PORT_WIDTH-1:0] wdata_s;
  logic [PORT_WIDTH-1:0] rd_word_s;
  logic [PORT_WIDTH-1:0] port_reg_s;
  logic [7:0]       rd_data_s;
  logic             unused_wdata_s;

  // Address decode: window hit, port index and register select.
  always_comb begin
    hit_s      = ({1'b0, in_addr} >= ADDR_LO) && ({1'b0, in_addr} < ADDR_HI);
    offset_s   = in_addr - BASE_ADDR;
    port_idx_s = offset_s[9:2];
    reg_sel_s  = offset_s[1:0];
    wr_s       = in_write_en & hit_s;
    wdata_s    = in_data[PORT_WIDTH-1:0];
  end

  // Upper data bits are deliberately discarded for narrow ports.
  assign unused_wdata_s = ^in_data;

  // Next-state: synchroniser chain, register writes and edge capture.
  always_comb begin
    sync1_d    = in_port;
    sync2_d    = sync1_q;
    prev_d     = sync2_q;
    rising_s   = sync2_q & ~prev_q;
    data_out_d = data_out_q;
    mask_d     = mask_q;
    pend_d     = pend_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      data_out_d[p*PORT_WIDTH +: PORT_WIDTH] =
        (wr_s && port_idx_s == 8'(p) && reg_sel_s == 2'd1) ? wdata_s
                                                            : data_out_q[p*PORT_WIDTH +: PORT_WIDTH];
      mask_d[p*PORT_WIDTH +: PORT_WIDTH] =
        (wr_s && port_idx_s == 8'(p) && reg_sel_s == 2'd3) ? wdata_s
                                                            : mask_q[p*PORT_WIDTH +: PORT_WIDTH];
      // Clear first, then OR in new captures so a same-edge edge wins.
      pend_d[p*PORT_WIDTH +: PORT_WIDTH] =
        ((wr_s && port_idx_s == 8'(p) && reg_sel_s == 2'd2)
           ? (pend_q[p*PORT_WIDTH +: PORT_WIDTH] & ~wdata_s)
           : pend_q[p*PORT_WIDTH +: PORT_WIDTH])
        | (rising_s[p*PORT_WIDTH +: PORT_WIDTH] & mask_q[p*PORT_WIDTH +: PORT_WIDTH]);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      data_out_q <= '0;
      pend_q     <= '0;
      mask_q     <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      data_out_q <= data_out_d;
      pend_q     <= pend_d;
      mask_q     <= mask_d;
    end
  end

  // Combinational read mux, zero-extended to the bus width.
  always_comb begin
    rd_word_s  = '0;
    port_reg_s = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      case (reg_sel_s)
        2'd0:    port_reg_s = sync2_q[p*PORT_WIDTH +: PORT_WIDTH];
        2'd1:    port_reg_s = data_out_q[p*PORT_WIDTH +: PORT_WIDTH];
        2'd2:    port_reg_s = pend_q[p*PORT_WIDTH +: PORT_WIDTH];
        2'd3:    port_reg_s = mask_q[p*PORT_WIDTH +: PORT_WIDTH];
        default: port_reg_s = '0;
      endcase
      rd_word_s = rd_word_s | ({PORT_WIDTH{port_idx_s == 8'(p)}} & port_reg_s);
    end
    rd_data_s = '0;
    rd_data_s[PORT_WIDTH-1:0] = rd_word_s;
  end

  // A simultaneous write takes priority and keeps the bus released.
  assign out_data = (in_read_en && hit_s && !in_write_en) ? rd_data_s : {8{1'bz}};
  assign out_port = data_out_q;
  assign out_irq  = |(pend_q & mask_q);

endmodule

// File: tb/tb_io_port_bank.sv
module tb_io_port_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] in_addr;
  logic       in_write_en;
  logic       in_read_en;
  logic [7:0] in_data;
  wire  [7:0] bus_w;
  logic [7:0] in_port;
  wire  [7:0] out_port;
  wire        out_irq;

  // Bench-side bus keeper: a released DUT bus reads back the keeper value.
  logic       keeper_en;
  logic [7:0] keeper_val;
  assign bus_w = keeper_en ? keeper_val : 8'bz;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got;
  logic [7:0] exp_v;

  always #5 clk = ~clk;

  io_port_bank dut (
    .clk        (clk),
    .rst        (rst),
    .in_addr    (in_addr),
    .in_write_en(in_write_en),
    .in_read_en (in_read_en),
    .in_data    (in_data),
    .out_data   (bus_w),
    .in_port    (in_port),
    .out_port   (out_port),
    .out_irq    (out_irq)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [9:0] a, input logic [7:0] d);
    in_addr     = a;
    in_data     = d;
    in_write_en = 1'b1;
    tick();
    in_write_en = 1'b0;
  endtask

  task automatic bus_read(input logic [9:0] a, output logic [7:0] d);
    in_addr    = a;
    in_read_en = 1'b1;
    #2;
    d = bus_w;
    #1;
    in_read_en = 1'b0;
  endtask

  // Read an address and compare against the oldest scoreboard entry.
  task automatic read_cmp(input logic [9:0] a, input string name);
    bus_read(a, got);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL %s: read %h got %h expected %h", name, a, got, exp_v);
    end
  endtask

  task automatic test_output_write();
    bus_write(10'h3F1, 8'hA5);
    n_checks++;
    if (out_port !== 8'h05) begin
      n_fail++;
      $display("FAIL out_port_p0: got %h expected %h", out_port, 8'h05);
    end
    exp_q.push_back(8'h05);
    read_cmp(10'h3F1, "dout0_rb");
    bus_write(10'h3F5, 8'h0C);
    n_checks++;
    if (out_port !== 8'hC5) begin
      n_fail++;
      $display("FAIL out_port_p1: got %h expected %h", out_port, 8'hC5);
    end
    exp_q.push_back(8'h0C);
    read_cmp(10'h3F5, "dout1_rb");
  endtask

  task automatic test_input_sync();
    in_port = 8'h90;
    exp_q.push_back(8'h00);
    read_cmp(10'h3F4, "din1_edge0");
    tick();
    exp_q.push_back(8'h00);
    read_cmp(10'h3F4, "din1_edge1");
    tick();
    exp_q.push_back(8'h09);
    read_cmp(10'h3F4, "din1_edge2");
    tick();
    exp_q.push_back(8'h09);
    read_cmp(10'h3F4, "din1_edge3");
  endtask

  task automatic test_edge_irq();
    bus_write(10'h3F3, 8'h03);
    in_port = 8'h95;
    tick();
    tick();
    exp_q.push_back(8'h00);
    read_cmp(10'h3F2, "pend0_edge2");
    n_checks++;
    if (out_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_edge2: got %b expected %b", out_irq, 1'b0);
    end
    tick();
    exp_q.push_back(8'h01);
    read_cmp(10'h3F2, "pend0_edge3");
    n_checks++;
    if (out_irq !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_edge3: got %b expected %b", out_irq, 1'b1);
    end
    bus_write(10'h3F2, 8'h01);
    exp_q.push_back(8'h00);
    read_cmp(10'h3F2, "pend0_w1c");
    n_checks++;
    if (out_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_w1c: got %b expected %b", out_irq, 1'b0);
    end
  endtask

  task automatic test_set_wins();
    in_port = 8'h94;
    for (int i = 0; i < 3; i++) tick();
    in_port = 8'h95;
    for (int i = 0; i < 3; i++) tick();
    exp_q.push_back(8'h01);
    read_cmp(10'h3F2, "pend0_recapture");
    in_port = 8'h94;
    for (int i = 0; i < 3; i++) tick();
    exp_q.push_back(8'h01);
    read_cmp(10'h3F2, "pend0_hold");
    in_port = 8'h95;
    tick();
    tick();
    // W1C commits on the same edge that captures the new rising edge.
    bus_write(10'h3F2, 8'h01);
    exp_q.push_back(8'h01);
    read_cmp(10'h3F2, "pend0_set_wins");
    n_checks++;
    if (out_irq !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_set_wins: got %b expected %b", out_irq, 1'b1);
    end
  endtask

  task automatic test_decode();
    bus_write(10'h3EF, 8'hFF);
    bus_write(10'h3F8, 8'hFF);
    n_checks++;
    if (out_port !== 8'hC5) begin
      n_fail++;
      $display("FAIL out_port_miss: got %h expected %h", out_port, 8'hC5);
    end
    n_checks++;
    if (out_irq !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_miss: got %b expected %b", out_irq, 1'b1);
    end
    exp_q.push_back(8'h03);
    read_cmp(10'h3F3, "mask0_miss");
    exp_q.push_back(8'h0C);
    read_cmp(10'h3F5, "dout1_miss");
    keeper_en = 1'b1;
    keeper_val = 8'h5A;
    exp_q.push_back(8'h5A);
    read_cmp(10'h3EF, "z_below");
    exp_q.push_back(8'h5A);
    read_cmp(10'h3F8, "z_above");
    keeper_val = 8'hA5;
    exp_q.push_back(8'hA5);
    read_cmp(10'h3F8, "z_above_alt");
    // Read and write together on a hit: write happens, bus stays released.
    keeper_val  = 8'h5A;
    exp_q.push_back(8'h5A);
    in_addr     = 10'h3F1;
    in_data     = 8'h03;
    in_write_en = 1'b1;
    in_read_en  = 1'b1;
    #2;
    got = bus_w;
    tick();
    in_write_en = 1'b0;
    in_read_en  = 1'b0;
    keeper_en   = 1'b0;
    exp_v = exp_q.pop_front();
    n_checks++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL z_rd_wr: got %h expected %h", got, exp_v);
    end
    n_checks++;
    if (out_port !== 8'hC3) begin
      n_fail++;
      $display("FAIL out_port_rd_wr: got %h expected %h", out_port, 8'hC3);
    end
    exp_q.push_back(8'h03);
    read_cmp(10'h3F1, "dout0_rd_wr");
    bus_write(10'h3F0, 8'hFF);
    exp_q.push_back(8'h05);
    read_cmp(10'h3F0, "din0_ro");
    bus_write(10'h3F2, 8'h00);
    exp_q.push_back(8'h01);
    read_cmp(10'h3F2, "pend0_w0");
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    in_addr     = 10'h3F1;
    in_data     = 8'hFF;
    in_write_en = 1'b1;
    tick();
    rst         = 1'b0;
    in_write_en = 1'b0;
    n_checks++;
    if (out_port !== 8'h00) begin
      n_fail++;
      $display("FAIL out_port_reset: got %h expected %h", out_port, 8'h00);
    end
    n_checks++;
    if (out_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_reset: got %b expected %b", out_irq, 1'b0);
    end
    for (int a = 0; a < 8; a++) begin
      exp_q.push_back(8'h00);
      read_cmp(10'h3F0 + 10'(a), "reg_reset");
    end
  endtask

  initial begin
    rst         = 1'b1;
    in_addr     = 10'h000;
    in_write_en = 1'b0;
    in_read_en  = 1'b0;
    in_data     = 8'h00;
    in_port     = 8'h00;
    keeper_en   = 1'b0;
    keeper_val  = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    tick();
    test_output_write();
    test_input_sync();
    test_edge_irq();
    test_set_wins();
    test_decode();
    test_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/io_port_bank.md
# io_port_bank

Parametrised memory-mapped I/O port block for the DRF system, the successor to the fixed single 4-bit in/out port pair. It provides NUM_PORTS independent ports of PORT_WIDTH bits. Each port has a synchronised input, a registered output, and rising-edge capture with a per-bit mask and a combined interrupt request. It sits on the shared 8-bit data BUS, decoded from the 10-bit data-memory address {bank selector, BUS}, alongside data_memory.

## Interface
- NUM_PORTS, 2, number of ports; legal range 1..16.
- PORT_WIDTH, 4, bits per port; legal range 1..8.
- BASE_ADDR, 10'h3F0, first address of the register window. Must be a multiple of 4, and BASE_ADDR + 4*NUM_PORTS must be ≤ 1024.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_addr  input  10  data-memory address.
- in_write_en  input  1  bus write strobe.
- in_read_en  input  1  bus read strobe.
- in_data  input  8  write data from BUS.
- out_data  output  8  read data onto BUS; high-Z when not selected.
- in_port  input  NUM_PORTS*PORT_WIDTH  external pins, asynchronous; port p occupies bits [p*PORT_WIDTH +: PORT_WIDTH].
- out_port  output  NUM_PORTS*PORT_WIDTH  registered output pins, same packing as in_port.
- out_irq  output  1  OR over all ports of (pending & mask).

## Operation
- Register window: offset = in_addr − BASE_ADDR; port p = offset[..:2]; reg = offset[1:0].
- A hit is defined as BASE_ADDR ≤ in_addr < BASE_ADDR + 4*NUM_PORTS. On a miss, writes are ignored and out_data is high-Z.
- reg 0 DATA_IN (RO): synchronised input value. Writes are ignored.
- reg 1 DATA_OUT (RW): drives out_port.
- reg 2 PEND (R/W1C): latched rising edges. Writing 1 clears the bit; writing 0 has no effect.
- reg 3 MASK (RW): enables edge capture and irq contribution per bit.
- Width rule: writes use in_data[PORT_WIDTH-1:0] and discard the upper bits. Reads zero-extend to 8 bits.
- Input path per bit: sync1 ← pin; sync2 ← sync1; prev ← sync2. A rising edge is sync2 & ~prev.
- PEND bit sets on (rising & MASK bit). Clearing MASK does not clear PEND; it only stops new captures and masks the bit out of irq.
- Simultaneous W1C and new rising edge on the same bit: set wins, and the bit stays 1.
- in_write_en and in_read_en both high: the write is performed and out_data is high-Z.
- Read is side-effect free; reading PEND does not clear it.
- Reset (any cycle, including mid-access): sync1, sync2, prev, DATA_OUT, PEND and MASK all go to 0. out_port = 0 and out_irq = 0 from the cycle after the rst edge. Any write in the reset cycle is discarded.
- Pin high at reset release: seen as a rising edge (prev = 0). It is captured only if MASK was written first.

## Timing
- Writes commit at the clk edge where in_write_en and hit are both high. out_port and register readback reflect the new value in the following cycle.
- Reads are combinational from the registers: out_data is valid in the same cycle that in_read_en and hit are high, with zero wait states.
- Pin change to DATA_IN readback: visible after 2 clk edges.
- Pin rising to PEND set: at the 3rd clk edge after the pin change, provided the pin is stable over the synchroniser window. out_irq follows combinationally in the same cycle.
- Pulses shorter than one clk period may be missed; this is not required to be detected.
- W1C at edge N: PEND reads 0 and out_irq drops in cycle N+1, unless a new edge is captured at edge N.

## Test plan
- Reset: drive rst for 1 cycle with prior nonzero state → out_port = 0, out_irq = 0, and reads of all 4*NUM_PORTS registers return 8'h00.
- Output write (defaults): write 8'hA5 to 10'h3F1 → port 0 out_port[3:0] = 4'h5 next cycle, readback = 8'h05. Write 8'h0C to 10'h3F5 → out_port[7:4] = 4'hC, with port 0 unchanged.
- Input sync: set in_port[7:4] = 4'h9 → read 10'h3F4 returns 8'h00 one cycle later and 8'h09 from the 2nd edge onward.
- Edge capture/irq: MASK0 = 4'h3, raise pin bits 0 and 2 → PEND0 = 4'h1 at the 3rd edge and out_irq = 1. Write 8'h01 to 10'h3F2 → PEND0 = 0 and out_irq = 0.
- Set-wins collision: time the W1C of PEND0 bit0 to the same edge as a new captured rising edge on bit0 → PEND0 bit0 stays 1 and out_irq stays 1.
- Decode/bus: access 10'h3EF and 10'h3F8 with read and write → no state change and out_data = Z. Access with read and write both high on 10'h3F1 → write occurs and out_data = Z.
